// File: rtl/fsm_cmd_sequencer.sv
// Command sequencer: issues an encoded target command to a downstream FSM, waits
// for matching status with timeout/retry, and reports done or an error cause.
module fsm_cmd_sequencer #(
    parameter int TIMEOUT   = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_target,
    input  logic [2:0] status_in,
    output logic [2:0] cmd_out,
    output logic       cmd_valid,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    input  logic       err_clear,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] RETRY_MAX  = 3'(MAX_RETRY);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and nothing is queued while it is low.

    state_t     state, next_state;
    logic [1:0] target, target_d;
    logic [7:0] timer;
    logic [2:0] retry_cnt;
    logic [1:0] err_code_d;
    logic       accept;
    logic       retry_inc;

    function automatic logic [2:0] encode(input logic [1:0] t);
        logic [2:0] code;
        case (t)
            2'd3:    code = 3'h0;
            2'd2:    code = 3'h4;
            2'd1:    code = 3'h5;
            default: code = 3'h0;
        endcase
        return code;
    endfunction

    assign req_ready = (state == IDLE);
    assign state_dbg = state;
    assign target_d  = accept ? req_target : target;

    always_comb begin
        next_state = state;
        err_code_d = err_code;
        accept     = 1'b0;
        retry_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    // Target 0 has no command code, so it fails without issuing.
                    if (req_target == 2'd0) begin
                        next_state = ERR;
                        err_code_d = 2'b01;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (!status_in[2]) begin
                    next_state = ERR;
                    err_code_d = 2'b11;
                end else if (status_in[1:0] == target) begin
                    next_state = DONE;
                end else if (timer == TIMER_LAST) begin
                    if (retry_cnt < RETRY_MAX) begin
                        retry_inc  = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = ERR;
                        err_code_d = 2'b10;
                    end
                end
            end
            DONE: next_state = IDLE;
            ERR: begin
                if (err_clear) next_state = IDLE;
            end
            default: begin
                next_state = ERR;
                err_code_d = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target    <= 2'd0;
            timer     <= 8'd0;
            retry_cnt <= 3'd0;
            cmd_out   <= 3'h0;
            cmd_valid <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            target    <= target_d;
            cmd_valid <= (next_state == ISSUE);
            done      <= (next_state == DONE);
            error     <= (next_state == ERR);
            err_code  <= (next_state == ERR) ? err_code_d : 2'b00;
            if (next_state == ISSUE) begin
                cmd_out <= encode(target_d);
            end
            if (state == ISSUE) begin
                timer <= 8'd0;
            end else if (state == WAIT && timer != 8'hff) begin
                timer <= timer + 8'd1;
            end
            if (accept) begin
                retry_cnt <= 3'd0;
            end else if (retry_inc && retry_cnt != 3'd7) begin
                retry_cnt <= retry_cnt + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_cmd_sequencer.sv
// Directed bench for fsm_cmd_sequencer: success, target-0 error, retry/timeout,
// bad status, mid-operation reset, and a random sweep for illegal commands/states.
module tb_fsm_cmd_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_target;
    logic [2:0] status_in;
    logic [2:0] cmd_out;
    logic       cmd_valid;
    logic       done;
    logic       error;
    logic [1:0] err_code;
    logic       err_clear;
    logic [2:0] state_dbg;

    int tests;
    int fails;

    fsm_cmd_sequencer #(.TIMEOUT(8), .MAX_RETRY(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .status_in  (status_in),
        .cmd_out    (cmd_out),
        .cmd_valid  (cmd_valid),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .err_clear  (err_clear),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_err();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("clear_ready", {7'd0, req_ready}, 8'd1);
        chk("clear_error", {7'd0, error}, 8'd0);
    endtask

    initial begin
        int p_cnt;
        int p_cyc[3];
        int err_first;
        int done_seen;
        int bad_cmd;
        int bad_state;
        int illegal_run;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_target = 2'd0;
        status_in = 3'b100;
        err_clear = 1'b0;

        // Reset state
        #12;
        chk("rst_cmd_out", {5'd0, cmd_out}, 8'h0);
        chk("rst_cmd_valid", {7'd0, cmd_valid}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_error", {7'd0, error}, 8'd0);
        chk("rst_err_code", {6'd0, err_code}, 8'd0);
        chk("rst_ready", {7'd0, req_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Target 2 succeeds: cmd_valid at N+1, done at N+3
        req_valid = 1'b1;
        req_target = 2'd2;
        status_in = 3'b110;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t2_n1_cmd_valid", {7'd0, cmd_valid}, 8'd1);
        chk("t2_n1_cmd_out", {5'd0, cmd_out}, 8'h4);
        chk("t2_n1_ready", {7'd0, req_ready}, 8'd0);
        @(negedge clk);
        chk("t2_n2_cmd_valid", {7'd0, cmd_valid}, 8'd0);
        chk("t2_n2_done", {7'd0, done}, 8'd0);
        chk("t2_n2_state", {5'd0, state_dbg}, 8'd2);
        @(negedge clk);
        chk("t2_n3_done", {7'd0, done}, 8'd1);
        chk("t2_n3_cmd_out", {5'd0, cmd_out}, 8'h4);
        @(negedge clk);
        chk("t2_n4_done", {7'd0, done}, 8'd0);
        chk("t2_n4_ready", {7'd0, req_ready}, 8'd1);
        chk("t2_n4_cmd_out", {5'd0, cmd_out}, 8'h4);

        // Target 0: straight to ERR code 01, no command
        req_valid = 1'b1;
        req_target = 2'd0;
        @(negedge clk);
        chk("t0_error", {7'd0, error}, 8'd1);
        chk("t0_err_code", {6'd0, err_code}, 8'd1);
        chk("t0_cmd_valid", {7'd0, cmd_valid}, 8'd0);
        chk("t0_cmd_out_held", {5'd0, cmd_out}, 8'h4);
        req_target = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t0_hold_error", {7'd0, error}, 8'd1);
        chk("t0_hold_code", {6'd0, err_code}, 8'd1);
        chk("t0_no_cmd", {7'd0, cmd_valid}, 8'd0);
        clear_err();
        @(negedge clk);

        // Target 1, status stuck at 3'b111: three issues 9 cycles apart then code 10
        req_valid = 1'b1;
        req_target = 2'd1;
        status_in = 3'b111;
        p_cnt = 0;
        err_first = 0;
        done_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 1'b0;
            if (c == 3) begin
                req_valid = 1'b1;
                req_target = 2'd2;
            end
            if (c == 7) req_valid = 1'b0;
            if (cmd_valid) begin
                if (p_cnt < 3) p_cyc[p_cnt] = c;
                p_cnt++;
            end
            if (done) done_seen++;
            if (error && err_first == 0) err_first = c;
        end
        chk("retry_pulses", 8'(p_cnt), 8'd3);
        chk("retry_p0", 8'(p_cyc[0]), 8'd1);
        chk("retry_p1", 8'(p_cyc[1]), 8'd10);
        chk("retry_p2", 8'(p_cyc[2]), 8'd19);
        chk("retry_err_cycle", 8'(err_first), 8'd28);
        chk("retry_err_code", {6'd0, err_code}, 8'd2);
        chk("retry_cmd_out", {5'd0, cmd_out}, 8'h5);
        chk("retry_no_done", 8'(done_seen), 8'd0);
        clear_err();
        @(negedge clk);

        // Target 3 with status_in[2]=0 in WAIT -> code 11 next cycle
        req_valid = 1'b1;
        req_target = 2'd3;
        status_in = 3'b011;
        @(negedge clk);
        req_valid = 1'b0;
        chk("t3_cmd_out", {5'd0, cmd_out}, 8'h0);
        chk("t3_cmd_valid", {7'd0, cmd_valid}, 8'd1);
        @(negedge clk);
        chk("t3_wait_no_err", {7'd0, error}, 8'd0);
        @(negedge clk);
        chk("t3_error", {7'd0, error}, 8'd1);
        chk("t3_err_code", {6'd0, err_code}, 8'd3);
        clear_err();
        @(negedge clk);

        // Reset pulsed during WAIT
        req_valid = 1'b1;
        req_target = 2'd1;
        status_in = 3'b111;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rw_in_wait", {5'd0, state_dbg}, 8'd2);
        rst_n = 1'b0;
        #1;
        chk("rw_cmd_out", {5'd0, cmd_out}, 8'h0);
        chk("rw_cmd_valid", {7'd0, cmd_valid}, 8'd0);
        chk("rw_error", {7'd0, error}, 8'd0);
        chk("rw_err_code", {6'd0, err_code}, 8'd0);
        chk("rw_ready", {7'd0, req_ready}, 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        err_first = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || error || cmd_valid) done_seen++;
        end
        chk("rw_quiet", 8'(done_seen), 8'd0);
        req_valid = 1'b1;
        req_target = 2'd2;
        status_in = 3'b110;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rw_new_cmd_out", {5'd0, cmd_out}, 8'h4);
        @(negedge clk);
        @(negedge clk);
        chk("rw_new_done", {7'd0, done}, 8'd1);
        @(negedge clk);

        // Random sweep
        bad_cmd = 0;
        bad_state = 0;
        illegal_run = 0;
        for (int c = 0; c < 10000; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_target = 2'($urandom_range(0, 3));
            status_in = 3'($urandom_range(0, 7));
            err_clear = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (cmd_out == 3'h6 || cmd_out == 3'h7) bad_cmd++;
            if (state_dbg > 3'd4) illegal_run++;
            else illegal_run = 0;
            if (illegal_run > 1) bad_state++;
        end
        err_clear = 1'b0;
        chk("rand_cmd_legal", 8'(bad_cmd), 8'd0);
        chk("rand_state_legal", 8'(bad_state), 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
